// File: rtl/seq_array_mult_gen.sv
// Iterative shift-add multiplier: one partial product per clock, signed/unsigned
// operands, valid/ready handshakes on the operand and result sides.
module seq_array_mult_gen #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE, out_valid only in DONE; a
    // producer holds in_valid until accepted, the product holds until out_ready.

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mag_x, mag_y;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               neg;
    logic [WIDTH:0]     sum;
    logic               last_iter;

    assign last_iter = (count == CW'(WIDTH - 1));

    // Upper half plus carry; the carry becomes the MSB after the right shift.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mag_y[0] ? mag_x : '0)};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)  state_nxt = CALC;
            CALC: if (last_iter) state_nxt = FIX;
            FIX:                 state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_x <= '0;
            mag_y <= '0;
            acc   <= '0;
            count <= '0;
            neg   <= 1'b0;
            P     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // -2^(W-1) negates to itself, which reads correctly as unsigned.
                        mag_x <= (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
                        mag_y <= (is_signed && y[WIDTH-1]) ? (~y + WIDTH'(1)) : y;
                        neg   <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        acc   <= '0;
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= {sum, acc[WIDTH-1:1]};
                    mag_y <= mag_y >> 1;
                    count <= count + CW'(1);
                end
                FIX: begin
                    P <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == FIX);
    assign dbg_state = state;

endmodule

// File: doc/seq_array_mult_gen.md
Name: seq_array_mult_gen

Overview:
- Parametrised, iterative shift-add multiplier. Successor to the 32-bit combinational array multiplier.
- Trades area for latency: one partial product per clock.
- Adds a signed/unsigned mode select and valid/ready handshakes on both the input and output sides.
- Sits between operand producers (ALU issue logic) and result consumers that may stall.

Parameters:
WIDTH, 32, operand width in bits; legal range WIDTH >= 2; product width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands x, y, is_signed are valid this cycle
in_ready  output  1  block can accept operands
x  input  WIDTH  multiplicand
y  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  P holds a completed product
out_ready  input  1  consumer accepts P this cycle
P  output  2*WIDTH  product
busy  output  1  high in CALC and FIX states

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; all internal registers are cleared.
  - Outputs: in_ready=1, out_valid=0, busy=0, P=0.
  - Reset takes effect immediately in any state. An operation in flight is discarded and produces no out_valid.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge:
    - Register mag_x = |x| and mag_y = |y| when is_signed=1; otherwise register x and y unchanged.
    - Register neg = is_signed & (x[W-1] ^ y[W-1]).
    - Clear the accumulator (2*WIDTH bits) and the count.
    - Go to CALC.
  - Operand ports are not sampled after the accept edge. Changes in later cycles have no effect.
- CALC:
  - Each cycle, if mag_y[0]=1, add mag_x into the upper WIDTH+1 bits of the accumulator.
  - Shift the {carry, accumulator} pair right by 1 and shift mag_y right by 1.
  - count increments; after exactly WIDTH iterations go to FIX.
- FIX:
  - P = neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits.
  - Set out_valid=1 and go to DONE.
- DONE:
  - out_valid=1 and P stays stable until out_ready=1 at a clock edge.
  - On that edge: out_valid=0 and go to IDLE. P keeps its last value until the next FIX.
  - in_ready=0, so no new operands are accepted until IDLE.
- Latency: if operands are accepted at edge E, out_valid first reads high after edge E+WIDTH+1.
- Minimum initiation interval: WIDTH+3 cycles, with out_ready held high.
- Magnitude rule:
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) is represented exactly in WIDTH unsigned bits; no overflow.
  - Maximum magnitude product, (2^W-1)^2 unsigned or 2^(2W-2) signed, fits in 2*WIDTH bits.
  - The result always equals the exact mathematical product modulo 2^(2*WIDTH).
- Zero operands take the full WIDTH iterations; there is no early termination, so latency is constant.
- in_valid while not in IDLE is ignored; the producer must hold it until in_ready.
- out_ready while out_valid=0 is ignored.
- busy = (state==CALC) | (state==FIX).

Test Plan:
- WIDTH=32, unsigned, x=0x00000004, y=0x00000004 -> P=0x0000000000000010; out_valid high after accept edge +33.
- Unsigned x=y=0xFFFFFFFF -> P=0xFFFFFFFE00000001. Signed x=y=0xFFFFFFFF (-1*-1) -> P=0x0000000000000001.
- Signed x=0x80000000, y=0x80000000 -> P=0x4000000000000000. Signed x=0xFFFFFFFD (-3), y=0x00000005 -> P=0xFFFFFFFFFFFFFFF1.
- Backpressure: complete 7*9 with out_ready=0 for 10 cycles -> P=0x3F stable and out_valid held. Drive new in_valid during the stall -> in_ready=0 and the new operands are not taken. Then raise out_ready -> IDLE next edge and the next operation proceeds.
- Operand change: alter x and y every cycle during CALC -> P equals the product of the values sampled at the accept edge.
- Reset mid-operation: assert rst_n=0 at CALC iteration 12 -> out_valid=0, busy=0, P=0 immediately. After release, 2*3 completes with P=0x6. Also run WIDTH=8 with x=0x80, y=0x7F signed -> P=0xC080, latency 9.
